// File: rtl/csr_file_if.sv
// csr_file_if -- bundles the CSR file's read port, write port, trap strobes
// and architectural status outputs.
//   r_addr/r_data/r_illegal        : combinational CSR read port
//   csr_w_enabled/csr_w_addr/_data : write strobe from the write stage
//   instr_retired                  : one pulse per retired instruction
//   trap/trap_pc/trap_cause, mret  : trap entry / return strobes
//   mtvec_out/mepc_out/mie_out     : registered state for the fetch/IRQ logic
// The slave modport is the CSR file; the master modport is the core side.
interface csr_file_if;
    logic [11:0] r_addr;
    logic [31:0] r_data;
    logic        r_illegal;
    logic        csr_w_enabled;
    logic [11:0] csr_w_addr;
    logic [31:0] csr_w_data;
    logic        instr_retired;
    logic        trap;
    logic [31:0] trap_pc;
    logic [31:0] trap_cause;
    logic        mret;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        mie_out;

    modport slave (
        input  r_addr, csr_w_enabled, csr_w_addr, csr_w_data, instr_retired,
               trap, trap_pc, trap_cause, mret,
        output r_data, r_illegal, mtvec_out, mepc_out, mie_out
    );

    modport master (
        output r_addr, csr_w_enabled, csr_w_addr, csr_w_data, instr_retired,
               trap, trap_pc, trap_cause, mret,
        input  r_data, r_illegal, mtvec_out, mepc_out, mie_out
    );
endinterface

// File: rtl/csr_file.sv
// csr_file -- machine-mode CSR file: mstatus (MIE/MPIE, MPP fixed to M),
// mtvec, mscratch, mepc, mcause, read-only mhartid, and optional 64-bit
// mcycle/minstret counters with user-mode read shadows.
// Ports:
//   clk  : clock, all state updates on the rising edge
//   rstn : asynchronous active-low reset
//   bus  : csr_file_if.slave (read/write ports, trap/mret strobes, status)
// Parameters: MTVEC_RESET (mtvec reset value), HART_ID (mhartid value).
// Build option: define CSR_COUNTERS_EN to include the counters.
module csr_file #(
    parameter logic [31:0] MTVEC_RESET = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0
) (
    input  logic      clk,
    input  logic      rstn,
    csr_file_if.slave bus
);
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d;
    logic [31:0] mepc_q, mepc_d, mcause_q, mcause_d;
    logic [31:0] mstatus_rd;

    // MPP is hardwired to machine mode (2'b11).
    assign mstatus_rd = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};

    // Next state; later assignments win, giving trap > mret > CSR write on
    // each register independently.
    always_comb begin
        mie_d      = mie_q;
        mpie_d     = mpie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        if (bus.csr_w_enabled) begin
            case (bus.csr_w_addr)
                12'h300: begin
                    mie_d  = bus.csr_w_data[3];
                    mpie_d = bus.csr_w_data[7];
                end
                12'h305: mtvec_d    = bus.csr_w_data & ~32'h3;
                12'h340: mscratch_d = bus.csr_w_data;
                12'h341: mepc_d     = bus.csr_w_data & ~32'h3;
                12'h342: mcause_d   = bus.csr_w_data;
                default: ;
            endcase
        end
        if (bus.mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        if (bus.trap) begin
            mepc_d   = bus.trap_pc & ~32'h3;
            mcause_d = bus.trap_cause;
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mie_q      <= 1'b0;
            mpie_q     <= 1'b0;
            mtvec_q    <= MTVEC_RESET;
            mscratch_q <= 32'h0;
            mepc_q     <= 32'h0;
            mcause_q   <= 32'h0;
        end else begin
            mie_q      <= mie_d;
            mpie_q     <= mpie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
        end
    end

`ifdef CSR_COUNTERS_EN
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;

    // A write to either half loads that half and freezes the counter for
    // the cycle, so software sees exactly the value it wrote.
    always_comb begin
        mcycle_d   = mcycle_q + 64'd1;
        minstret_d = minstret_q + {63'd0, bus.instr_retired};
        if (bus.csr_w_enabled) begin
            case (bus.csr_w_addr)
                12'hB00: mcycle_d   = {mcycle_q[63:32], bus.csr_w_data};
                12'hB80: mcycle_d   = {bus.csr_w_data, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], bus.csr_w_data};
                12'hB82: minstret_d = {bus.csr_w_data, minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
        end else begin
            mcycle_q   <= mcycle_d;
            minstret_q <= minstret_d;
        end
    end
`else
    logic unused_instr_retired;
    assign unused_instr_retired = bus.instr_retired;
`endif

    // Read mux returns pre-edge state; no bypass of a same-cycle write.
    always_comb begin
        bus.r_data    = 32'h0;
        bus.r_illegal = 1'b0;
        case (bus.r_addr)
            12'h300: bus.r_data = mstatus_rd;
            12'h305: bus.r_data = mtvec_q;
            12'h340: bus.r_data = mscratch_q;
            12'h341: bus.r_data = mepc_q;
            12'h342: bus.r_data = mcause_q;
            12'hF14: bus.r_data = HART_ID;
`ifdef CSR_COUNTERS_EN
            12'hB00, 12'hC00: bus.r_data = mcycle_q[31:0];
            12'hB80, 12'hC80: bus.r_data = mcycle_q[63:32];
            12'hB02, 12'hC02: bus.r_data = minstret_q[31:0];
            12'hB82, 12'hC82: bus.r_data = minstret_q[63:32];
`endif
            default: bus.r_illegal = 1'b1;
        endcase
    end

    assign bus.mtvec_out = mtvec_q;
    assign bus.mepc_out  = mepc_q;
    assign bus.mie_out   = mie_q;
endmodule

// File: doc/csr_file.md
CSR_FILE -- requirements
Module: csr_file

Interface
REQ-001 SHALL have parameter MTVEC_RESET, default 32'h0000_0000, the reset value of mtvec.
REQ-002 SHALL have parameter HART_ID, default 32'h0, the read-only value of mhartid.
REQ-003 SHALL have port clk  input  1  clock, all state updates on rising edge.
REQ-004 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port r_addr  input  12  CSR read address.
REQ-006 SHALL have port r_data  output  32  combinational read data for r_addr.
REQ-007 SHALL have port r_illegal  output  1  high when r_addr is not implemented.
REQ-008 SHALL have port csr_w_enabled  input  1  write strobe from the write stage.
REQ-009 SHALL have port csr_w_addr  input  12  write address.
REQ-010 SHALL have port csr_w_data  input  32  write data.
REQ-011 SHALL have port instr_retired  input  1  one-cycle pulse per retired instruction.
REQ-012 SHALL have ports trap (input, 1, take trap), trap_pc (input, 32, faulting PC) and trap_cause (input, 32, cause code).
REQ-013 SHALL have port mret  input  1  return-from-trap strobe.
REQ-014 SHALL have ports mtvec_out (output, 32), mepc_out (output, 32) and mie_out (output, 1, mstatus.MIE), all driven directly from registers.

Function
REQ-015 SHALL implement mstatus 0x300, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342 as read/write, and mhartid 0xF14 as read-only.
REQ-016 SHALL implement mstatus as MIE bit 3 and MPIE bit 7, with bits 12:11 (MPP) reading 2'b11 and all other bits reading 0; writes SHALL affect only bits 3 and 7.
REQ-017 SHALL force mtvec[1:0] and mepc[1:0] to 0 on every write and every trap.
REQ-018 SHALL return the pre-edge register value on r_data, with no bypass of a same-cycle write.
REQ-019 SHALL drive r_data=0 and r_illegal=1 for an unimplemented r_addr.
REQ-020 SHALL make a write visible on the cycle after the edge at which csr_w_enabled is sampled high.
REQ-021 SHALL silently ignore writes to read-only or unimplemented addresses.
REQ-022 SHALL on trap: mepc<=trap_pc with bits [1:0] cleared, mcause<=trap_cause, MPIE<=MIE, MIE<=0.
REQ-023 SHALL on mret (without trap): MIE<=MPIE, MPIE<=1.
REQ-024 SHALL apply same-cycle priority trap > mret > CSR write, per affected register; lower-priority updates to registers touched by the winner are dropped, and registers not touched by the winner still take the write.
REQ-025 SHALL treat trap and mret as the full trap-state transitions of REQ-022/023, with no handshake; each strobe acts once per cycle it is high.

Reset
REQ-026 SHALL asynchronously clear mstatus, mscratch, mepc, mcause and all counters to 0, and load mtvec with MTVEC_RESET, while rstn=0.
REQ-027 SHALL drive mtvec_out=MTVEC_RESET, mepc_out=0 and mie_out=0 during reset; r_data then reflects the reset values.
REQ-028 SHALL start counting on the first rising edge after rstn deasserts.

Configuration
REQ-029 SHALL, with macro CSR_COUNTERS_EN defined, implement 64-bit mcycle (0xB00/0xB80) and minstret (0xB02/0xB82) as read/write, plus read-only shadows cycle (0xC00/0xC80) and instret (0xC02/0xC82).
REQ-030 SHALL increment mcycle by 1 every cycle and minstret by 1 per cycle with instr_retired=1, both wrapping from 2^64-1 to 0.
REQ-031 SHALL, on a write to a counter half, load that half with csr_w_data and suppress that cycle's increment for the counter; the other half SHALL hold.
REQ-032 SHALL, without CSR_COUNTERS_EN, omit all counter addresses, which then read 0 with r_illegal=1 and ignore writes.

Verification
REQ-033 Reset: hold rstn=0, read 0x305 with MTVEC_RESET=32'h8000_0000 -> r_data=32'h8000_0000, mie_out=0, r_illegal=0.
REQ-034 Write/read: write 0x340=32'hDEAD_BEEF, read in the same cycle -> old value 0; next cycle -> 32'hDEAD_BEEF. Write 0xF14 -> value unchanged.
REQ-035 Trap/mret: set MIE=1, then trap with trap_pc=32'h0000_1007 and cause=11 -> mepc=32'h0000_1004, mcause=11, mstatus=32'h0000_1880. Then mret -> mstatus=32'h0000_1888.
REQ-036 Collision: trap and a csr write to 0x341 with 32'h40 in the same cycle -> mepc holds the trap value; the same cycle's write to 0x340 still lands.
REQ-037 Counters (CSR_COUNTERS_EN): write 0xB00=32'hFFFF_FFFF and 0xB80=32'hFFFF_FFFF -> after 1 cycle mcycle wraps to 0. Pulse instr_retired 3 times -> instret low = 3.
REQ-038 Build without CSR_COUNTERS_EN: read 0xC00 -> r_data=0, r_illegal=1.
